// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit path among NUM_REQ byte sources.
// Acts as sole master on the UART register port. It polls STATUS for TX FIFO
// space, then writes each byte to the TX register. Grants are round-robin per
// message, so bytes from different sources never interleave in the FIFO.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [8*NUM_REQ-1:0]         req_data,
  input  logic [NUM_REQ-1:0]           req_last,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic [7:0]                   uart_address,
  output logic [31:0]                  uart_write_data,
  output logic                         uart_we,
  output logic                         uart_re,
  input  logic [31:0]                  uart_read_data,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic                         lock_abort
);

  localparam int                IdW         = $clog2(NUM_REQ);
  localparam logic [7:0]        STATUS_ADDR = 8'h08;
  localparam logic [7:0]        TX_ADDR     = 8'h0C;
  localparam logic [15:0]       IDLE_LIMIT  = 16'(LOCK_TIMEOUT - 1);
  localparam logic [IdW-1:0]    PTR_RESET   = IdW'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_POLL  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  // One-hot select for the requester being served.
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IdW-1:0] idx);
    onehot = NUM_REQ'(1'b1) << idx;
  endfunction

  state_t            state_r, state_s;
  logic [IdW-1:0]    ptr_r, ptr_s;
  logic              lock_r, lock_s;
  logic [IdW-1:0]    owner_r, owner_s;
  logic [15:0]       idle_cnt_r, idle_cnt_s;
  logic              abort_s;

  logic              found_s;
  logic [IdW-1:0]    pick_s;
  logic [IdW-1:0]    cand_s;
  logic [7:0]        owner_byte_s;

  logic [NUM_REQ-1:0] req_ready_r;
  logic [7:0]         uart_address_r;
  logic [31:0]        uart_write_data_r;
  logic               uart_we_r;
  logic               busy_r;
  logic               lock_abort_r;

  // Only the FIFO-full flag of STATUS matters; the other bits are ignored.
  logic unused_rd_bits_s;
  assign unused_rd_bits_s = ^{uart_read_data[31:2], uart_read_data[0]};

  assign owner_byte_s = req_data[{owner_r, 3'b000} +: 8];

  // Round-robin search starting just after the last granted index.
  always_comb begin
    found_s = 1'b0;
    pick_s  = {IdW{1'b0}};
    cand_s  = {IdW{1'b0}};
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand_s = IdW'((int'(ptr_r) + i) % NUM_REQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        pick_s  = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic: arbitration, lock tracking, STATUS poll and TX write.
  always_comb begin
    state_s    = state_r;
    ptr_s      = ptr_r;
    lock_s     = lock_r;
    owner_s    = owner_r;
    idle_cnt_s = idle_cnt_r;
    abort_s    = 1'b0;
    case (state_r)
      ST_ARB: begin
        if (lock_r) begin
          // Timeout takes priority over a valid arriving in the same cycle.
          if (idle_cnt_r == IDLE_LIMIT) begin
            lock_s     = 1'b0;
            ptr_s      = owner_r;
            abort_s    = 1'b1;
            idle_cnt_s = 16'd0;
          end else if (req_valid[owner_r]) begin
            state_s    = ST_POLL;
            idle_cnt_s = 16'd0;
          end else begin
            idle_cnt_s = idle_cnt_r + 16'd1;
          end
        end else if (enable && found_s) begin
          owner_s = pick_s;
          state_s = ST_POLL;
        end else begin
          state_s = ST_ARB;
        end
      end
      ST_POLL: begin
        if (!uart_read_data[1]) begin
          state_s = ST_WRITE;
        end else begin
          state_s = ST_POLL;
        end
      end
      ST_WRITE: begin
        state_s = ST_ARB;
        if (req_last[owner_r]) begin
          lock_s = 1'b0;
          ptr_s  = owner_r;
        end else begin
          lock_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_ARB;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_ARB;
      ptr_r      <= PTR_RESET;
      lock_r     <= 1'b0;
      owner_r    <= {IdW{1'b0}};
      idle_cnt_r <= 16'd0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      lock_r     <= lock_s;
      owner_r    <= owner_s;
      idle_cnt_r <= idle_cnt_s;
    end
  end

  // Registered outputs, decoded from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_ready_r       <= {NUM_REQ{1'b0}};
      uart_address_r    <= STATUS_ADDR;
      uart_write_data_r <= 32'd0;
      uart_we_r         <= 1'b0;
      busy_r            <= 1'b0;
      lock_abort_r      <= 1'b0;
    end else begin
      req_ready_r       <= (state_s == ST_WRITE) ? onehot(owner_s) : {NUM_REQ{1'b0}};
      uart_address_r    <= (state_s == ST_WRITE) ? TX_ADDR : STATUS_ADDR;
      uart_write_data_r <= (state_s == ST_WRITE) ? {24'd0, owner_byte_s} : 32'd0;
      uart_we_r         <= (state_s == ST_WRITE);
      busy_r            <= (state_s != ST_ARB) || lock_s;
      lock_abort_r      <= abort_s;
    end
  end

  assign req_ready       = req_ready_r;
  assign uart_address    = uart_address_r;
  assign uart_write_data = uart_write_data_r;
  assign uart_we         = uart_we_r;
  assign uart_re         = 1'b0;
  assign grant_id        = owner_r;
  assign busy            = busy_r;
  assign lock_abort      = lock_abort_r;

endmodule
